md_unit_param: RTL

//  Parametrised multiply/divide unit with HI/LO for the execute stage of the pipelined MIPS core.

---
 rtl/md_unit_param.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/md_unit_param.sv
// Parametrised multiply/divide unit with HI/LO registers for the MIPS execute stage.
// The result is computed once when the op is accepted, then held until the latency counter expires.
module md_unit_param #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned MUL_CYCLES = 5,
  parameter int unsigned DIV_CYCLES = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       md_op,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  input  logic             flush,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  localparam int unsigned MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);
  localparam int unsigned PW      = 2 * WIDTH;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0]   pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic               done_q, done_d;

  logic [PW-1:0]      prod_s, prod_u;
  logic [WIDTH-1:0]   a_mag, b_mag, b_safe, q_mag, r_mag, q_s, r_s;
  logic [WIDTH-1:0]   d2_safe, q_u, r_u;
  logic [WIDTH-1:0]   res_hi, res_lo;
  logic               a_neg, b_neg;

  // Result datapath; signed divide works on magnitudes so the -2^(W-1)/-1 case wraps to itself.
  always_comb begin
    a_neg   = data1[WIDTH-1];
    b_neg   = data2[WIDTH-1];
    prod_s  = {{WIDTH{a_neg}}, data1} * {{WIDTH{b_neg}}, data2};
    prod_u  = {{WIDTH{1'b0}}, data1} * {{WIDTH{1'b0}}, data2};
    a_mag   = a_neg ? (~data1 + WIDTH'(1)) : data1;
    b_mag   = b_neg ? (~data2 + WIDTH'(1)) : data2;
    b_safe  = (b_mag == '0) ? WIDTH'(1) : b_mag;
    q_mag   = a_mag / b_safe;
    r_mag   = a_mag % b_safe;
    q_s     = (a_neg ^ b_neg) ? (~q_mag + WIDTH'(1)) : q_mag;
    r_s     = a_neg ? (~r_mag + WIDTH'(1)) : r_mag;
    d2_safe = (data2 == '0) ? WIDTH'(1) : data2;
    q_u     = data1 / d2_safe;
    r_u     = data1 % d2_safe;
    res_hi  = '0;
    res_lo  = '0;
    case (md_op)
      OP_MULT:  begin res_hi = prod_s[PW-1:WIDTH]; res_lo = prod_s[WIDTH-1:0]; end
      OP_MULTU: begin res_hi = prod_u[PW-1:WIDTH]; res_lo = prod_u[WIDTH-1:0]; end
      OP_DIV:   begin res_hi = (data2 == '0) ? data1 : r_s; res_lo = (data2 == '0) ? '1 : q_s; end
      OP_DIVU:  begin res_hi = (data2 == '0) ? data1 : r_u; res_lo = (data2 == '0) ? '1 : q_u; end
      default:  ;
    endcase
  end

  // Next-state and register updates; flush beats both accept and completion.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !flush) begin
          case (md_op)
            OP_MULT, OP_MULTU: begin
              pend_hi_d = res_hi;
              pend_lo_d = res_lo;
              cnt_d     = CNT_W'(MUL_CYCLES);
              state_d   = RUN;
            end
            OP_DIV, OP_DIVU: begin
              pend_hi_d = res_hi;
              pend_lo_d = res_lo;
              cnt_d     = CNT_W'(DIV_CYCLES);
              state_d   = RUN;
            end
            OP_MTHI: hi_d = data1;
            OP_MTLO: lo_d = data1;
            default: ;
          endcase
        end
      end
      RUN: begin
        if (flush) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(1)) begin
          hi_d    = pend_hi_q;
          lo_d    = pend_lo_q;
          done_d  = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      done_q    <= done_d;
    end
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign busy = (state_q == RUN);
  assign done = done_q;

endmodule
